// File: rtl/conv_scheduler_if.sv
// conv_scheduler_if
// Bundles every strobe, address and stream handshake between the convolution
// phase sequencer and the blocks it drives. Clock and reset stay outside.
//
// master (sequencer side):
//   in : s_valid_x, m_ready_y
//   out: s_ready_x, x_wr_en, x_wr_addr, x_rd_addr (lane i at [i*ADDRX +: ADDRX]),
//        f_addr, clr_acc, en_acc, y_wr_en, y_wr_addr, y_wr_mask, y_rd_addr,
//        m_valid_y, done
// slave (environment side): the same signals with directions reversed.
interface conv_scheduler_if #(
   parameter int P     = 2,
   parameter int ADDRX = 3,
   parameter int ADDRF = 2
);
   logic                 s_valid_x;
   logic                 s_ready_x;
   logic                 x_wr_en;
   logic [ADDRX-1:0]     x_wr_addr;
   logic [P*ADDRX-1:0]   x_rd_addr;
   logic [ADDRF-1:0]     f_addr;
   logic                 clr_acc;
   logic                 en_acc;
   logic                 y_wr_en;
   logic [ADDRX-1:0]     y_wr_addr;
   logic [P-1:0]         y_wr_mask;
   logic [ADDRX-1:0]     y_rd_addr;
   logic                 m_valid_y;
   logic                 m_ready_y;
   logic                 done;

   modport master (
      input  s_valid_x, m_ready_y,
      output s_ready_x, x_wr_en, x_wr_addr, x_rd_addr, f_addr, clr_acc, en_acc,
             y_wr_en, y_wr_addr, y_wr_mask, y_rd_addr, m_valid_y, done
   );

   modport slave (
      output s_valid_x, m_ready_y,
      input  s_ready_x, x_wr_en, x_wr_addr, x_rd_addr, f_addr, clr_acc, en_acc,
             y_wr_en, y_wr_addr, y_wr_mask, y_rd_addr, m_valid_y, done
   );
endinterface

// File: rtl/conv_scheduler.sv
// conv_scheduler
// Phase sequencer for the P-lane 1-D convolution datapath. Loads LENX samples
// from the input stream into the X memories, runs ceil(SIZE/P) groups of
// LENF-tap MACs (SIZE = LENX-LENF+1), writes each group into the output
// buffer, then streams the buffer out one word at a time.
//
// Ports:
//   clk   : single clock
//   reset : asynchronous, active-high; returns to LOAD with all counters 0
//   bus   : conv_scheduler_if.master (sample stream in, X/F/Y memory control,
//           MAC strobes, output stream, done pulse)
module conv_scheduler #(
   parameter int LENX  = 8,
   parameter int LENF  = 4,
   parameter int P     = 2,
   parameter int ADDRX = 3,
   parameter int ADDRF = 2
) (
   input logic              clk,
   input logic              reset,
   conv_scheduler_if.master bus
);
   localparam int SIZE = LENX - LENF + 1;
   // c runs 0..LENF inclusive, so it needs one bit more than the ROM address
   localparam int CW = ADDRF + 1;

   localparam logic [ADDRX:0]   SIZE_X = (ADDRX+1)'(SIZE);
   localparam logic [ADDRX:0]   P_X    = (ADDRX+1)'(P);
   localparam logic [ADDRX-1:0] LAST_X = ADDRX'(LENX - 1);
   localparam logic [ADDRX-1:0] LAST_Y = ADDRX'(SIZE - 1);
   localparam logic [CW-1:0]    LENF_C = CW'(LENF);

   typedef enum logic [1:0] {LOAD, COMPUTE, WRITE, DRAIN} state_t;

   state_t           state;
   logic [ADDRX-1:0] ld_cnt;
   logic [ADDRX-1:0] base;
   logic [ADDRX-1:0] rd_addr;
   logic [CW-1:0]    c;
   logic             m_valid;
   logic             done_r;

   logic [ADDRX:0]   base_x;
   logic [ADDRX:0]   base_next_x;
   logic [ADDRX:0]   lane_x;
   logic [ADDRX:0]   sum_x;
   logic             ready;
   logic             wr;

   // Lane and group arithmetic is one bit wider than the address so that
   // base+i+c and base+P compare against SIZE without wrapping.
   assign base_x      = {1'b0, base};
   assign base_next_x = base_x + P_X;

   // Reset state is LOAD, but the stream must not see ready while reset is held.
   assign ready = (state == LOAD) && !reset;
   assign wr    = bus.s_valid_x && ready;

   assign bus.s_ready_x = ready;
   assign bus.x_wr_en   = wr;
   assign bus.x_wr_addr = ld_cnt;
   assign bus.y_rd_addr = rd_addr;
   assign bus.m_valid_y = m_valid;
   assign bus.done      = done_r;

   always_comb begin
      bus.clr_acc   = 1'b0;
      bus.en_acc    = 1'b0;
      bus.f_addr    = '0;
      bus.x_rd_addr = '0;
      bus.y_wr_en   = 1'b0;
      bus.y_wr_addr = '0;
      bus.y_wr_mask = '0;
      lane_x        = '0;
      sum_x         = '0;
      if (state == COMPUTE) begin
         // Reads issue at c=0..LENF-1; the memories answer one cycle later,
         // so accumulation runs at c=1..LENF.
         bus.clr_acc = (c == '0);
         bus.en_acc  = (c != '0);
         if (c < LENF_C) begin
            bus.f_addr = c[ADDRF-1:0];
            for (int i = 0; i < P; i++) begin
               lane_x = base_x + (ADDRX+1)'(i);
               sum_x  = lane_x + (ADDRX+1)'(c);
               // Lanes past the last output still run; park them on a legal
               // address, their result is masked off at write time.
               if (lane_x >= SIZE_X)
                  bus.x_rd_addr[i*ADDRX +: ADDRX] = LAST_X;
               else
                  bus.x_rd_addr[i*ADDRX +: ADDRX] = sum_x[ADDRX-1:0];
            end
         end
      end
      if (state == WRITE) begin
         bus.y_wr_en   = 1'b1;
         bus.y_wr_addr = base;
         for (int i = 0; i < P; i++) begin
            lane_x           = base_x + (ADDRX+1)'(i);
            bus.y_wr_mask[i] = (lane_x < SIZE_X);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= LOAD;
         ld_cnt  <= '0;
         base    <= '0;
         rd_addr <= '0;
         c       <= '0;
         m_valid <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            LOAD: begin
               if (wr) begin
                  if (ld_cnt == LAST_X) begin
                     ld_cnt <= '0;
                     base   <= '0;
                     c      <= '0;
                     state  <= COMPUTE;
                  end else begin
                     ld_cnt <= ld_cnt + ADDRX'(1);
                  end
               end
            end
            COMPUTE: begin
               if (c == LENF_C) begin
                  c     <= '0;
                  state <= WRITE;
               end else begin
                  c <= c + CW'(1);
               end
            end
            WRITE: begin
               if (base_next_x < SIZE_X) begin
                  base  <= base_next_x[ADDRX-1:0];
                  state <= COMPUTE;
               end else begin
                  base    <= '0;
                  rd_addr <= '0;
                  m_valid <= 1'b0;
                  state   <= DRAIN;
               end
            end
            DRAIN: begin
               // m_valid low marks the buffer fetch cycle for rd_addr.
               if (!m_valid) begin
                  m_valid <= 1'b1;
               end else if (bus.m_ready_y) begin
                  m_valid <= 1'b0;
                  if (rd_addr == LAST_Y) begin
                     rd_addr <= '0;
                     done_r  <= 1'b1;
                     state   <= LOAD;
                  end else begin
                     rd_addr <= rd_addr + ADDRX'(1);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_scheduler.sv
// tb_conv_scheduler
// Scoreboard bench for conv_scheduler in two configurations: the default
// (LENX=8, LENF=4, P=2) and LENX=9, LENF=3, P=4. Stimulus pushes expected
// events into queues; monitors pop and compare whenever the DUT presents a
// write strobe, a MAC strobe, an output handshake or done.
`timescale 1ns/1ps
module tb_conv_scheduler;
   localparam int LENX0 = 8, LENF0 = 4, P0 = 2, AX0 = 3, AF0 = 2, SIZE0 = 5;
   localparam int LENX1 = 9, LENF1 = 3, P1 = 4, AX1 = 4, AF1 = 2, SIZE1 = 7;

   logic clk = 1'b0;
   logic rst0;
   logic rst1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   conv_scheduler_if #(.P(P0), .ADDRX(AX0), .ADDRF(AF0)) bus0 ();
   conv_scheduler_if #(.P(P1), .ADDRX(AX1), .ADDRF(AF1)) bus1 ();

   conv_scheduler #(.LENX(LENX0), .LENF(LENF0), .P(P0), .ADDRX(AX0), .ADDRF(AF0))
      dut0 (.clk(clk), .reset(rst0), .bus(bus0));
   conv_scheduler #(.LENX(LENX1), .LENF(LENF1), .P(P1), .ADDRX(AX1), .ADDRF(AF1))
      dut1 (.clk(clk), .reset(rst1), .bus(bus1));

   typedef struct packed {
      logic             clr;
      logic             en;
      logic             ywr;
      logic             chk;
      logic [AF0-1:0]   f;
      logic [P0*AX0-1:0] xr;
      logic [AX0-1:0]   ya;
      logic [P0-1:0]    m;
   } ev0_t;

   typedef struct packed {
      logic [AX1-1:0] ya;
      logic [P1-1:0]  m;
   } ev1_t;

   ev0_t           q_ev0[$];
   logic [AX0-1:0] q_xw0[$];
   logic [AX0-1:0] q_hs0[$];
   ev1_t           q_ev1[$];
   logic [AX1-1:0] q_hs1[$];

   int rdy_mode0 = 0;   // 0 low, 1 held high, 2 random
   int rdy_mode1 = 0;
   int hs_cnt0 = 0, done_cnt0 = 0, wr_cnt0 = 0;
   int hs_cnt1 = 0, done_cnt1 = 0;
   int last_wr0 = 0, last_hs0 = -1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset0(string nm);
      chk(nm, 64'({bus0.s_ready_x, bus0.x_wr_en, bus0.x_wr_addr, bus0.x_rd_addr,
                   bus0.f_addr, bus0.clr_acc, bus0.en_acc, bus0.y_wr_en,
                   bus0.y_wr_addr, bus0.y_wr_mask, bus0.y_rd_addr,
                   bus0.m_valid_y, bus0.done}), 64'd0);
   endtask

   task automatic check_reset1(string nm);
      chk(nm, 64'({bus1.s_ready_x, bus1.x_wr_en, bus1.x_wr_addr, bus1.x_rd_addr,
                   bus1.f_addr, bus1.clr_acc, bus1.en_acc, bus1.y_wr_en,
                   bus1.y_wr_addr, bus1.y_wr_mask, bus1.y_rd_addr,
                   bus1.m_valid_y, bus1.done}), 64'd0);
   endtask

   // Expected x writes, MAC strobe cycles, group writes and drain order for
   // the default configuration. Masks are the hand values 11, 11, 01.
   task automatic push_run0();
      logic [1:0] masks [3];
      ev0_t e;
      masks[0] = 2'b11; masks[1] = 2'b11; masks[2] = 2'b01;
      for (int k = 0; k < LENX0; k++) q_xw0.push_back(AX0'(k));
      for (int g = 0; g < 3; g++) begin
         int b;
         b = 2 * g;
         for (int c = 0; c <= LENF0; c++) begin
            e = '0;
            e.clr = (c == 0);
            e.en  = (c != 0);
            e.chk = (c < LENF0);
            if (c < LENF0) begin
               e.f = AF0'(c);
               for (int i = 0; i < P0; i++)
                  e.xr[i*AX0 +: AX0] = (b + i >= SIZE0) ? AX0'(LENX0 - 1) : AX0'(b + i + c);
            end
            q_ev0.push_back(e);
         end
         e = '0;
         e.ywr = 1'b1;
         e.ya  = AX0'(b);
         e.m   = masks[g];
         q_ev0.push_back(e);
      end
      for (int k = 0; k < SIZE0; k++) q_hs0.push_back(AX0'(k));
   endtask

   task automatic flush0();
      q_ev0.delete();
      q_xw0.delete();
      q_hs0.delete();
   endtask

   // input ready driver
   initial begin
      bus0.m_ready_y = 1'b0;
      bus1.m_ready_y = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus0.m_ready_y = (rdy_mode0 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode0 == 1);
         bus1.m_ready_y = (rdy_mode1 == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode1 == 1);
      end
   end

   // monitor, default configuration
   initial begin
      ev0_t           e;
      logic [AX0-1:0] a;
      logic           ok;
      logic           pv0, pr0, exp_done0;
      logic [AX0-1:0] pa0;
      int             gap;
      pv0 = 1'b0; pr0 = 1'b0; pa0 = '0; exp_done0 = 1'b0;
      forever begin
         @(negedge clk);
         if (rst0) begin
            pv0 = 1'b0;
            exp_done0 = 1'b0;
         end else begin
            if (bus0.x_wr_en) begin
               vectors++;
               if (q_xw0.size() == 0) begin
                  miscompares++;
                  $display("FAIL xwr0: unexpected write at addr %0d, expected none", bus0.x_wr_addr);
               end else begin
                  a = q_xw0.pop_front();
                  if (bus0.x_wr_addr !== a) begin
                     miscompares++;
                     $display("FAIL xwr0: addr %0d, expected %0d", bus0.x_wr_addr, a);
                  end
               end
            end
            if (bus0.clr_acc || bus0.en_acc || bus0.y_wr_en) begin
               vectors++;
               if (bus0.y_wr_en) begin
                  last_wr0 = cyc;
                  wr_cnt0++;
               end
               if (q_ev0.size() == 0) begin
                  miscompares++;
                  $display("FAIL ctl0: unexpected strobe clr=%b en=%b ywr=%b, expected none",
                           bus0.clr_acc, bus0.en_acc, bus0.y_wr_en);
               end else begin
                  e = q_ev0.pop_front();
                  ok = (bus0.clr_acc === e.clr) && (bus0.en_acc === e.en) && (bus0.y_wr_en === e.ywr);
                  if (e.chk) ok = ok && (bus0.f_addr === e.f) && (bus0.x_rd_addr === e.xr);
                  if (e.ywr) ok = ok && (bus0.y_wr_addr === e.ya) && (bus0.y_wr_mask === e.m);
                  if (!ok) begin
                     miscompares++;
                     $display("FAIL ctl0: clr=%b en=%b ywr=%b f=%0d xr=%h ya=%0d m=%b, expected clr=%b en=%b ywr=%b f=%0d xr=%h ya=%0d m=%b",
                              bus0.clr_acc, bus0.en_acc, bus0.y_wr_en, bus0.f_addr, bus0.x_rd_addr,
                              bus0.y_wr_addr, bus0.y_wr_mask, e.clr, e.en, e.ywr, e.f, e.xr, e.ya, e.m);
                  end
               end
            end
            if (exp_done0 || bus0.done) begin
               vectors++;
               if (!(exp_done0 && bus0.done && bus0.s_ready_x)) begin
                  miscompares++;
                  $display("FAIL done0: done=%b s_ready_x=%b, expected done=%b s_ready_x=1",
                           bus0.done, bus0.s_ready_x, exp_done0);
               end
            end
            exp_done0 = 1'b0;
            if (pv0 && !pr0) begin
               vectors++;
               if (!(bus0.m_valid_y === 1'b1 && bus0.y_rd_addr === pa0)) begin
                  miscompares++;
                  $display("FAIL hold0: valid=%b addr=%0d, expected valid=1 addr=%0d",
                           bus0.m_valid_y, bus0.y_rd_addr, pa0);
               end
            end
            if (bus0.m_valid_y && bus0.m_ready_y) begin
               vectors++;
               if (q_hs0.size() == 0) begin
                  miscompares++;
                  $display("FAIL hs0: unexpected handshake addr %0d, expected none", bus0.y_rd_addr);
               end else begin
                  a = q_hs0.pop_front();
                  if (bus0.y_rd_addr !== a) begin
                     miscompares++;
                     $display("FAIL hs0: addr %0d, expected %0d", bus0.y_rd_addr, a);
                  end
                  if (a == AX0'(SIZE0 - 1)) exp_done0 = 1'b1;
               end
               if (rdy_mode0 == 1) begin
                  vectors++;
                  gap = (last_hs0 > last_wr0) ? cyc - last_hs0 : cyc - last_wr0;
                  if (gap != 2) begin
                     miscompares++;
                     $display("FAIL hs0_spacing: %0d cycles, expected 2", gap);
                  end
               end
               last_hs0 = cyc;
               hs_cnt0++;
            end
            if (bus0.done) done_cnt0++;
            pv0 = bus0.m_valid_y;
            pr0 = bus0.m_ready_y;
            pa0 = bus0.y_rd_addr;
         end
      end
   end

   // monitor, LENX=9 LENF=3 P=4
   initial begin
      ev1_t           e;
      logic [AX1-1:0] a;
      logic           exp_done1;
      exp_done1 = 1'b0;
      forever begin
         @(negedge clk);
         if (rst1) begin
            exp_done1 = 1'b0;
         end else begin
            if (bus1.y_wr_en) begin
               vectors++;
               if (q_ev1.size() == 0) begin
                  miscompares++;
                  $display("FAIL ywr1: unexpected write base %0d, expected none", bus1.y_wr_addr);
               end else begin
                  e = q_ev1.pop_front();
                  if (bus1.y_wr_addr !== e.ya || bus1.y_wr_mask !== e.m) begin
                     miscompares++;
                     $display("FAIL ywr1: base %0d mask %b, expected base %0d mask %b",
                              bus1.y_wr_addr, bus1.y_wr_mask, e.ya, e.m);
                  end
               end
            end
            if (exp_done1 || bus1.done) begin
               vectors++;
               if (!(exp_done1 && bus1.done && bus1.s_ready_x)) begin
                  miscompares++;
                  $display("FAIL done1: done=%b s_ready_x=%b, expected done=%b s_ready_x=1",
                           bus1.done, bus1.s_ready_x, exp_done1);
               end
            end
            exp_done1 = 1'b0;
            if (bus1.m_valid_y && bus1.m_ready_y) begin
               vectors++;
               if (q_hs1.size() == 0) begin
                  miscompares++;
                  $display("FAIL hs1: unexpected handshake addr %0d, expected none", bus1.y_rd_addr);
               end else begin
                  a = q_hs1.pop_front();
                  if (bus1.y_rd_addr !== a) begin
                     miscompares++;
                     $display("FAIL hs1: addr %0d, expected %0d", bus1.y_rd_addr, a);
                  end
                  if (a == AX1'(SIZE1 - 1)) exp_done1 = 1'b1;
               end
               hs_cnt1++;
            end
            if (bus1.done) done_cnt1++;
         end
      end
   end

   // stimulus
   initial begin
      int n, guard, d0, h0, w0, d1, h1;
      ev1_t e1;
      rst0 = 1'b1;
      rst1 = 1'b1;
      bus0.s_valid_x = 1'b1;
      bus1.s_valid_x = 1'b1;
      rdy_mode0 = 1;
      rdy_mode1 = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset0("rst0_outputs");
      check_reset1("rst1_outputs");

      // run 1: back-to-back load, s_valid_x pulsing afterwards, ready held high
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      bus0.s_valid_x = 1'b0;
      @(negedge clk);
      chk("s_ready_after_reset0", 64'(bus0.s_ready_x), 64'd1);
      push_run0();
      @(posedge clk);
      #1;
      bus0.s_valid_x = 1'b1;
      @(negedge clk);
      n = 0;
      guard = 0;
      while (1) begin
         if (bus0.x_wr_en) n++;
         if (n >= LENX0 || guard >= 100) break;
         @(negedge clk);
         guard++;
      end
      chk("load_writes0", 64'(n), 64'(LENX0));
      @(negedge clk);
      chk("s_ready_in_compute0", 64'(bus0.s_ready_x), 64'd0);
      chk("clr_after_load0", 64'(bus0.clr_acc), 64'd1);
      d0 = done_cnt0;
      h0 = hs_cnt0;
      guard = 0;
      while (done_cnt0 == d0 && guard < 300) begin
         @(posedge clk);
         #1;
         if (hs_cnt0 - h0 >= SIZE0 - 1) bus0.s_valid_x = 1'b0;
         else bus0.s_valid_x = ~bus0.s_valid_x;
         guard++;
      end
      bus0.s_valid_x = 1'b0;
      chk("done_pulses_run1", 64'(done_cnt0 - d0), 64'd1);
      chk("handshakes_run1", 64'(hs_cnt0 - h0), 64'(SIZE0));
      chk("pending_run1", 64'(q_ev0.size() + q_xw0.size() + q_hs0.size()), 64'd0);
      repeat (2) @(negedge clk);
      chk("done_one_cycle0", 64'(done_cnt0 - d0), 64'd1);

      // run 2: gapped load, reset during the second group
      push_run0();
      n = 0;
      guard = 0;
      while (n < LENX0 && guard < 100) begin
         @(posedge clk);
         #1;
         bus0.s_valid_x = ~bus0.s_valid_x;
         @(negedge clk);
         if (bus0.x_wr_en) n++;
         guard++;
      end
      chk("gapped_writes0", 64'(n), 64'(LENX0));
      @(posedge clk);
      #1;
      bus0.s_valid_x = 1'b0;
      w0 = wr_cnt0;
      guard = 0;
      while (wr_cnt0 == w0 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("first_group_written0", 64'(wr_cnt0 - w0), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus0.s_valid_x = 1'b1;
      rst0 = 1'b1;
      @(negedge clk);
      check_reset0("rst0_mid_compute");
      flush0();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset0("rst0_held");
      push_run0();
      @(posedge clk);
      #1;
      rst0 = 1'b0;
      rdy_mode0 = 2;
      @(negedge clk);
      chk("s_ready_after_midreset0", 64'(bus0.s_ready_x), 64'd1);
      n = 0;
      guard = 0;
      while (1) begin
         if (bus0.x_wr_en) n++;
         if (n >= LENX0 || guard >= 100) break;
         @(negedge clk);
         guard++;
      end
      chk("reload_writes0", 64'(n), 64'(LENX0));
      @(posedge clk);
      #1;
      bus0.s_valid_x = 1'b0;
      d0 = done_cnt0;
      h0 = hs_cnt0;
      guard = 0;
      while (done_cnt0 == d0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      chk("done_pulses_run2", 64'(done_cnt0 - d0), 64'd1);
      chk("handshakes_run2", 64'(hs_cnt0 - h0), 64'(SIZE0));
      chk("pending_run2", 64'(q_ev0.size() + q_xw0.size() + q_hs0.size()), 64'd0);
      rdy_mode0 = 0;

      // run 3: LENX=9 LENF=3 P=4, SIZE=7
      e1.ya = 4'd0; e1.m = 4'b1111; q_ev1.push_back(e1);
      e1.ya = 4'd4; e1.m = 4'b0111; q_ev1.push_back(e1);
      for (int k = 0; k < SIZE1; k++) q_hs1.push_back(AX1'(k));
      @(posedge clk);
      #1;
      rst1 = 1'b0;
      @(negedge clk);
      chk("s_ready_after_reset1", 64'(bus1.s_ready_x), 64'd1);
      n = 0;
      guard = 0;
      while (1) begin
         if (bus1.x_wr_en) n++;
         if (n >= LENX1 || guard >= 100) break;
         @(negedge clk);
         guard++;
      end
      chk("load_writes1", 64'(n), 64'(LENX1));
      @(posedge clk);
      #1;
      bus1.s_valid_x = 1'b0;
      d1 = done_cnt1;
      h1 = hs_cnt1;
      guard = 0;
      while (done_cnt1 == d1 && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("done_pulses1", 64'(done_cnt1 - d1), 64'd1);
      chk("handshakes1", 64'(hs_cnt1 - h1), 64'(SIZE1));
      chk("pending1", 64'(q_ev1.size() + q_hs1.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
